// File: rtl/exc_chk_pkg.sv
// -----------------------------------------------------------------------------
// exc_chk_pkg
// Shared definitions for the exception-checker arbiter:
//   state_t      - arbiter FSM state encoding
//   EXC_*        - exception code values seen on Exc_out
//   is_special() - true when a single-precision exponent field is all ones
//                  (Inf or NaN), the only case where a checker code is valid
// -----------------------------------------------------------------------------
package exc_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [2:0] EXC_NONE    = 3'b000;
    localparam logic [2:0] EXC_INF     = 3'b011;
    localparam logic [2:0] EXC_NAN     = 3'b100;
    localparam logic [2:0] EXC_TIMEOUT = 3'b111;

    function automatic logic is_special(input logic [7:0] exp_field);
        return (exp_field == 8'hFF);
    endfunction

endpackage

// File: rtl/exc_chk_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection. The search starts at i_ptr and
// wraps modulo NUM_REQ; the first requester found with its request bit set wins.
// Ports:
//   i_req     [NUM_REQ-1:0]  request levels
//   i_ptr     [IW-1:0]       priority pointer (first index examined)
//   o_win_oh  [NUM_REQ-1:0]  one-hot winner (all zero when nothing requests)
//   o_win_idx [IW-1:0]       binary index of the winner
//   o_any                    at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
    import exc_chk_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_win_oh,
    output logic [IW-1:0]      o_win_idx,
    output logic               o_any
);

    always_comb begin
        int         w_pos;
        logic [IW-1:0] w_k;
        o_win_oh  = '0;
        o_win_idx = '0;
        o_any     = 1'b0;
        w_pos     = 0;
        w_k       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_pos = int'(i_ptr) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_k = IW'(w_pos);
            if (!o_any && i_req[w_k]) begin
                o_any         = 1'b1;
                o_win_idx     = w_k;
                o_win_oh[w_k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_chk_arbiter.sv
// -----------------------------------------------------------------------------
// exc_chk_arbiter
// Shares one floating-point exception checker between NUM_REQ requesters.
// A round-robin winner is chosen in IDLE, its operand is presented to the
// checker in ISSUE until acknowledged (or TIMEOUT cycles elapse), and the
// classification is returned with a one-cycle Done pulse in RESP.
//
//   state | meaning
//   IDLE  | no transaction; pick a winner when any Req is high
//   ISSUE | operand on Chk_data with Chk_valid=1; wait for Chk_ack or timeout
//   RESP  | Done[winner] pulse, Exc_out valid, Timeout_err if checker was silent
//
// Ports:
//   CLK, RSTN      clock, asynchronous active-low reset
//   Req            per-requester request level
//   Req_data       packed operands, slice i = requester i
//   Gnt            one-hot grant, high from ISSUE through RESP
//   Done           one-hot completion pulse (RESP cycle)
//   Exc_out        classification, held between Done pulses
//   Timeout_err    pulse in the RESP cycle when the checker never acknowledged
//   Chk_data       operand to the checker (holds last operand)
//   Chk_valid      operand valid to the checker (ISSUE only)
//   Chk_ack        checker acknowledge (ignored outside ISSUE)
//   Chk_exc        checker exception code
// -----------------------------------------------------------------------------
module exc_chk_arbiter
    import exc_chk_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [NUM_REQ-1:0]      Req,
    input  logic [32*NUM_REQ-1:0]   Req_data,
    output logic [NUM_REQ-1:0]      Gnt,
    output logic [NUM_REQ-1:0]      Done,
    output logic [2:0]              Exc_out,
    output logic                    Timeout_err,
    output logic [31:0]             Chk_data,
    output logic                    Chk_valid,
    input  logic                    Chk_ack,
    input  logic [2:0]              Chk_exc
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t              r_state;
    state_t              w_next_state;

    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_win_idx;
    logic [NUM_REQ-1:0]  r_win_oh;
    logic [31:0]         r_op;
    logic [2:0]          r_exc;
    logic [CW-1:0]       r_cnt;
    logic                r_timed_out;

    logic [NUM_REQ-1:0]  w_pick_oh;
    logic [IW-1:0]       w_pick_idx;
    logic                w_pick_any;
    logic                w_ack_take;
    logic                w_expire;
    logic [IW-1:0]       w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .i_req     (Req),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_pick_oh),
        .o_win_idx (w_pick_idx),
        .o_any     (w_pick_any)
    );

    // Acknowledge wins over expiry when both land in the last ISSUE cycle.
    assign w_ack_take = (r_state == ST_ISSUE) && Chk_ack;
    assign w_expire   = (r_state == ST_ISSUE) && !Chk_ack &&
                        (r_cnt == CW'(TIMEOUT - 1));

    assign w_ptr_next = (r_win_idx == IW'(NUM_REQ - 1)) ? '0 : (r_win_idx + IW'(1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        Gnt          = '0;
        Done         = '0;
        Chk_valid    = 1'b0;
        Timeout_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                Gnt       = r_win_oh;
                Chk_valid = 1'b1;
                if (w_ack_take || w_expire) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                Gnt          = r_win_oh;
                Done         = r_win_oh;
                Timeout_err  = r_timed_out;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ptr       <= '0;
            r_win_idx   <= '0;
            r_win_oh    <= '0;
            r_op        <= '0;
            r_exc       <= EXC_NONE;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_win_idx   <= w_pick_idx;
                        r_win_oh    <= w_pick_oh;
                        r_op        <= Req_data[{w_pick_idx, 5'd0} +: 32];
                        r_cnt       <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (w_ack_take) begin
                        // A code is only meaningful for Inf/NaN operands; anything
                        // else reports "none" so a stale checker output is dropped.
                        r_exc <= is_special(r_op[30:23]) ? Chk_exc : EXC_NONE;
                    end else if (w_expire) begin
                        r_exc       <= EXC_TIMEOUT;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_ptr <= w_ptr_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign Exc_out  = r_exc;
    assign Chk_data = r_op;

endmodule

// File: tb/tb_exc_chk_arbiter.sv
module tb_exc_chk_arbiter;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic            CLK;
    logic            RSTN;
    logic [N-1:0]    Req;
    logic [32*N-1:0] Req_data;
    logic [N-1:0]    Gnt;
    logic [N-1:0]    Done;
    logic [2:0]      Exc_out;
    logic            Timeout_err;
    logic [31:0]     Chk_data;
    logic            Chk_valid;
    logic            Chk_ack;
    logic [2:0]      Chk_exc;

    exc_chk_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .Req         (Req),
        .Req_data    (Req_data),
        .Gnt         (Gnt),
        .Done        (Done),
        .Exc_out     (Exc_out),
        .Timeout_err (Timeout_err),
        .Chk_data    (Chk_data),
        .Chk_valid   (Chk_valid),
        .Chk_ack     (Chk_ack),
        .Chk_exc     (Chk_exc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level reference state
    int          m_ptr;
    logic [N-1:0] m_pend;
    logic [31:0] m_data [N];
    logic [2:0]  m_exc_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen_data();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       r = {r[31], 8'hFF, 23'h0};
            1:       r = {r[31], 8'hFF, r[22:1], 1'b1};
            default: if (r[30:23] == 8'hFF) r[30] = 1'b0;
        endcase
        return r;
    endfunction

    task automatic drive_req();
        Req = m_pend;
        for (int i = 0; i < N; i++) Req_data[i*32 +: 32] = m_data[i];
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(Gnt), 0);
        chk({tag, "_done"},  32'(Done), 0);
        chk({tag, "_valid"}, 32'(Chk_valid), 0);
        chk({tag, "_data"},  Chk_data, 0);
        chk({tag, "_exc"},   32'(Exc_out), 0);
        chk({tag, "_tmo"},   32'(Timeout_err), 0);
    endtask

    task automatic do_reset();
        RSTN    = 1'b0;
        Chk_ack = 1'b0;
        Chk_exc = 3'b000;
        m_pend  = '0;
        m_ptr   = 0;
        m_exc_last = 3'b000;
        drive_req();
        repeat (2) @(negedge CLK);
        check_all_zero("rst");
        RSTN = 1'b1;
    endtask

    // Called at a negedge in an IDLE cycle; leaves at the next IDLE-cycle negedge.
    // d = ISSUE cycle (1-based) in which the checker acks; d > TMO means never.
    task automatic run_txn(input logic [N-1:0] add, input bit fixed_en, input logic [31:0] fixed,
                           input int d, input logic [2:0] exc, input bit drop_early,
                           input bit keep, output int w);
        int cyc;
        int exp_cyc;
        bit got;
        logic [31:0] wd;
        logic [2:0] exp_exc;
        for (int i = 0; i < N; i++) begin
            if (add[i] && !m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_data[i] = fixed_en ? fixed : gen_data();
            end
        end
        drive_req();
        w = -1;
        if (m_pend == '0) begin
            @(negedge CLK);
            chk("idle_nogrant", 32'(Gnt), 0);
            chk("idle_novalid", 32'(Chk_valid), 0);
            return;
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (w < 0 && m_pend[j]) w = j;
        end
        wd = m_data[w];
        @(negedge CLK);
        chk("gnt", 32'(Gnt), 32'(1 << w));
        chk("chk_valid", 32'(Chk_valid), 1);
        chk("chk_data", Chk_data, wd);
        chk("done_in_issue", 32'(Done), 0);
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= TMO + 3) begin
            Chk_ack = (cyc == d);
            Chk_exc = (cyc == d) ? exc : 3'($urandom);
            if (drop_early && cyc == 1) Req[w] = 1'b0;
            @(negedge CLK);
            if (Done != '0) got = 1'b1;
            else cyc++;
        end
        exp_cyc = (d >= 1 && d <= TMO) ? d : TMO;
        if (d >= 1 && d <= TMO) exp_exc = (wd[30:23] == 8'hFF) ? exc : 3'b000;
        else                    exp_exc = 3'b111;
        chk("issue_cycles", 32'(cyc), 32'(exp_cyc));
        chk("done", 32'(Done), 32'(1 << w));
        chk("gnt_resp", 32'(Gnt), 32'(1 << w));
        chk("valid_resp", 32'(Chk_valid), 0);
        chk("exc_out", 32'(Exc_out), 32'(exp_exc));
        chk("timeout_err", 32'(Timeout_err), 32'(d < 1 || d > TMO));
        m_exc_last = exp_exc;
        if (!keep) m_pend[w] = 1'b0;
        m_ptr = (w + 1) % N;
        drive_req();
        // stray acknowledge in RESP must not disturb anything
        Chk_ack = 1'($urandom);
        Chk_exc = 3'($urandom);
        @(negedge CLK);
        chk("gnt_idle", 32'(Gnt), 0);
        chk("done_idle", 32'(Done), 0);
        chk("valid_idle", 32'(Chk_valid), 0);
        chk("tmo_idle", 32'(Timeout_err), 0);
        chk("exc_hold", 32'(Exc_out), 32'(m_exc_last));
        chk("data_hold", Chk_data, wd);
        Chk_ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int d;
        int r;
        logic [N-1:0] add;
        bit drop;
        bit keep;

        RSTN     = 1'b0;
        Req      = '0;
        Req_data = '0;
        Chk_ack  = 1'b0;
        Chk_exc  = 3'b000;
        for (int i = 0; i < N; i++) m_data[i] = 32'h0;
        @(negedge CLK);
        do_reset();

        // single Inf request, immediate ack
        run_txn(4'b0100, 1'b1, 32'h7F800000, 1, 3'b011, 1'b0, 1'b0, w);
        chk("single_winner", 32'(w), 2);

        // normal operand, stale checker code suppressed
        run_txn(4'b0001, 1'b1, 32'h3F800000, 1, 3'b100, 1'b0, 1'b0, w);

        // timeout with checker silent
        run_txn(4'b0001, 1'b1, 32'h7FC00000, TMO + 1, 3'b100, 1'b0, 1'b0, w);

        // ack exactly in the last ISSUE cycle
        run_txn(4'b0010, 1'b1, 32'h7FC00000, TMO, 3'b100, 1'b0, 1'b0, w);

        // requester drops early, NaN operand
        do_reset();
        run_txn(4'b1000, 1'b1, 32'h7FC00001, 2, 3'b100, 1'b1, 1'b0, w);
        chk("drop_winner", 32'(w), 3);

        // all four continuously requesting from reset
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, 1'b0, 32'h0, 1, 3'($urandom), 1'b0, 1'b1, w);
            chk("rr_order", 32'(w), 32'(k % N));
        end

        // reset during ISSUE for requester 1 with pointer parked at 3
        do_reset();
        run_txn(4'b0100, 1'b0, 32'h0, 1, 3'b011, 1'b0, 1'b0, w);
        m_pend[1] = 1'b1;
        m_data[1] = 32'h7F800000;
        drive_req();
        @(negedge CLK);
        chk("pre_abort_gnt", 32'(Gnt), 32'b0010);
        Chk_ack = 1'b0;
        #2;
        RSTN = 1'b0;
        #1;
        check_all_zero("abort");
        m_ptr = 0;
        m_exc_last = 3'b000;
        repeat (2) begin
            @(negedge CLK);
            chk("abort_no_done", 32'(Done), 0);
        end
        RSTN = 1'b1;
        run_txn(4'b1010, 1'b0, 32'h0, 1, 3'b011, 1'b0, 1'b0, w);
        chk("post_abort_winner", 32'(w), 1);
        run_txn(4'b0000, 1'b0, 32'h0, 1, 3'b100, 1'b0, 1'b0, w);
        chk("post_abort_next", 32'(w), 3);

        // randomized traffic
        do_reset();
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      d = $urandom_range(1, 3);
            else if (r <= 7) d = $urandom_range(4, TMO);
            else if (r == 8) d = TMO + 1;
            else             d = TMO;
            add  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            keep = !drop && ($urandom_range(0, 7) == 0);
            run_txn(add, 1'b0, 32'h0, d, 3'($urandom), drop, keep, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
